// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// and a whole-pipeline freeze while MEM waits on the data-memory req/ack handshake.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             EXMEM_Branch,
  input  logic             EXMEM_Zero,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic             DMem_Ack,
  output logic             DMem_Req,
  output logic             PC_Write,
  output logic             PC_Src,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             PipeEn,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_MEM_DONE = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_q, timeout_d;

  logic mem_op;
  logic freeze;
  logic hazard_en;
  logic taken_branch;
  logic load_use;

  assign mem_op       = EXMEM_MemRead | EXMEM_MemWrite;
  assign taken_branch = EXMEM_Branch & EXMEM_Zero;
  assign load_use     = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                        ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze     = 1'b0;
    hazard_en  = 1'b0;
    DMem_Req   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_op) begin
          freeze     = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          hazard_en = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        freeze   = 1'b1;
        DMem_Req = 1'b1;
        // Ack arriving on the last allowed cycle still completes the access.
        if (DMem_Ack) begin
          state_d = S_MEM_DONE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_MEM_DONE: begin
        hazard_en = 1'b1;
        state_d   = S_RUN;
      end
      default: begin
        freeze = 1'b1;
      end
    endcase
  end

  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    PipeEn      = 1'b1;
    PC_Src      = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (freeze) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      PipeEn     = 1'b0;
    end else if (hazard_en) begin
      // A taken branch discards the younger instructions, so any load-use stall is moot.
      if (taken_branch) begin
        PC_Src      = 1'b1;
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
      end else if (load_use) begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q | (state_d == S_ERROR);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign MemTimeout = timeout_q;
  assign StallCount = stall_cnt_q;

endmodule
